key_expansion: RTL and testbench
================================

Name: key_expansion

Overview:
- Iterative AES-128 key schedule. Takes a 128-bit cipher key and emits the 11 round keys (index 0..10) one at a time over a valid/ready handshake.
- Output feeds the AddRoundKey stage directly upstream of SubBytes in the round datapath.
- Computes one round key per step from the previous one, using 4 Sbox instances rather than a full 16-byte substitution.

Parameters:
- BYTE, 8, bits per byte
- DWORD, 32, bits per word
- LENGTH, 128, key / state width in bits
- ROUNDS, 10, number of round keys after the initial key (last index = ROUNDS)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a key schedule; sampled only in IDLE
- key_in  input  LENGTH  cipher key; word w0 = key_in[127:96], byte 0 = key_in[127:120]
- rk_valid  output  1  rk_out / rk_index hold a valid round key
- rk_ready  input  1  consumer accepts the round key this cycle
- rk_out  output  LENGTH  current round key, same byte/word ordering as key_in
- rk_index  output  4  round number of rk_out, 0..ROUNDS
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after round key ROUNDS is accepted

Behaviour:
- Reset values, synchronous to clk, while rst=1: state=IDLE, rk_valid=0, rk_out=0, rk_index=0, busy=0, done=0, rcon=8'h01.
- States: IDLE, OUT, CALC, FIN.
- IDLE:
  - start=1 → latch key_in into the key register, rk_index=0, rcon=8'h01 → OUT.
  - rk_valid goes high on the cycle after start.
- OUT:
  - rk_valid=1; rk_out and rk_index are held stable while rk_ready=0.
  - On rk_valid&rk_ready with rk_index<ROUNDS → CALC.
  - On rk_valid&rk_ready with rk_index==ROUNDS → FIN.
- CALC (exactly one cycle, rk_valid=0):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - Register {w0',w1',w2',w3'}, increment rk_index, advance rcon → OUT.
- FIN: done=1 for one cycle, rk_valid=0 → IDLE.
- Latency:
  - start accepted at edge t → rk_valid=1 from t+1.
  - Handshake at edge u → next key valid from u+2.
  - With rk_ready tied high, a full schedule takes 1 + 11 + 10 + 1 = 23 cycles from start to the done pulse.
- Rcon advance: rcon = xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0). Sequence is 01,02,04,08,10,20,40,80,1B,36; no wrap is needed within ROUNDS=10.
- RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies Sbox to each of the 4 bytes.
- start while busy: ignored, with no effect on key, index or outputs.
- rk_ready while rk_valid=0: ignored.
- rk_ready held high: one key is transferred every 2 cycles.
- Reset mid-schedule: abandon immediately, all outputs take reset values, no done pulse.
- start in the same cycle as the FIN→IDLE transition: ignored; start is accepted only while in IDLE.
- key_in is sampled only on the start cycle; later changes do not affect an ongoing schedule.

Decomposition:
- Shared package aes_pkg:
  - BYTE, DWORD, LENGTH, ROUNDS constants
  - state encoding localparams
  - xtime function, shared with the future MixColumns stage
- Sub-module sub_word: 32-bit in/out, four Sbox instances, purely combinational. Instantiated once in key_expansion, on RotWord(w3).

Test Plan:
- Reset then FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1:
  - index 0 = key_in
  - index 1 = a0fafe1788542cb123a339392a6c7605
  - index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses once, 23 cycles after start
- All-zero key → index 1 = 62636363626363636263636362636363; checks the rcon/Sbox path with trivial input.
- Backpressure: rk_ready=0 for 5 cycles at index 3 → rk_out and rk_index=3 stable and rk_valid held high throughout; after release, index 4 appears 2 cycles after the handshake.
- start pulsed at index 5 with a different key_in → sequence unchanged and matches the FIPS-197 keys.
- rst asserted while rk_index=6 → next cycle rk_valid=0, busy=0, rk_index=0, no done. A fresh start then reproduces index 0..10 correctly, confirming rcon restarts at 01.
- Random rk_ready (~50% duty) over 20 random keys → all 11 keys match the reference model, each in ascending rk_index order with no duplicates.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and the GF(2^8) xtime helper.
// xtime is also intended for the MixColumns stage.
package aes_pkg;

    localparam int BYTE   = 8;
    localparam int DWORD  = 32;
    localparam int LENGTH = 128;
    localparam int ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_CALC = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel AES Sbox lookups on a 32-bit word, purely combinational.
// The byte-level Sbox is a constant table lookup.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

module sub_word
    import aes_pkg::*;
(
    input  logic [DWORD-1:0] word_in,
    output logic [DWORD-1:0] word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (word_in[i*BYTE +: BYTE]),
            .out_byte (word_out[i*BYTE +: BYTE])
        );
    end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..ROUNDS over valid/ready, one CALC cycle
// between keys (first key 1 cycle after start, next key 2 cycles after each handshake).
module key_expansion
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] key_in,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [LENGTH-1:0] rk_out,
    output logic [3:0]        rk_index,
    output logic              busy,
    output logic              done
);

    state_t          state;
    logic [BYTE-1:0] rcon;

    logic [DWORD-1:0] w0, w1, w2, w3;
    logic [DWORD-1:0] rot_w3, sub_w3, t;
    logic [DWORD-1:0] n0, n1, n2, n3;

    // rk_out doubles as the key register; the next key is derived from it directly.
    assign {w0, w1, w2, w3} = rk_out;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    sub_word u_sub_word (
        .word_in  (rot_w3),
        .word_out (sub_w3)
    );

    assign t  = sub_w3 ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_index <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rcon     <= 8'h01;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rk_out   <= key_in;
                        rk_index <= 4'd0;
                        rcon     <= 8'h01;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (rk_index == 4'(ROUNDS)) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rk_out   <= {n0, n1, n2, n3};
                    rk_index <= rk_index + 4'd1;
                    rcon     <= xtime(rcon);
                    rk_valid <= 1'b1;
                    state    <= ST_OUT;
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Directed and randomised checks of the AES-128 key schedule against FIPS-197 vectors
// and an independent GF(2^8)-derived reference model.
module tb_key_expansion;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [7:0]   sb [256];
    logic [127:0] model_keys [11];

    key_expansion dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Sbox from first principles: multiplicative inverse followed by the affine map.
    task automatic init_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] a, b, c, d, t;
        logic [7:0]  rc;
        rc = 8'h01;
        model_keys[0] = k;
        for (int r = 1; r <= 10; r++) begin
            {a, b, c, d} = model_keys[r-1];
            t = {sb[d[23:16]], sb[d[15:8]], sb[d[7:0]], sb[d[31:24]]} ^ {rc, 24'h0};
            a = a ^ t;
            b = b ^ a;
            c = c ^ b;
            d = d ^ c;
            model_keys[r] = {a, b, c, d};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    task automatic kick(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic drain;
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b required 0", busy);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; rk_ready = 1'b1; key_in = FIPS_KEY;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rk_valid, busy, done, rk_index} !== 7'd0 || rk_out !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b idx=%0d out=%h required all zero",
                     rk_valid, busy, done, rk_index, rk_out);
        end
        rst = 1'b0; start = 1'b0; rk_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, rk_valid);
        end
    endtask

    task automatic test_fips;
        int idx, ndone;
        idx = 0; ndone = 0;
        rk_ready = 1'b1;
        kick(FIPS_KEY);
        key_in = ~FIPS_KEY;
        for (int cyc = 1; cyc < 40; cyc++) begin
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (rk_index !== 4'(idx) || idx > 10 || rk_out !== fips[idx > 10 ? 10 : idx]) begin
                    n_fail++;
                    $display("FAIL fips_key: idx=%0d out=%h required idx=%0d", rk_index, rk_out, idx);
                end
                if (idx == 0) begin
                    n_checks++;
                    if (cyc != 1) begin
                        n_fail++;
                        $display("FAIL first_latency: key0 at cycle %0d required 1", cyc);
                    end
                end
                idx++;
            end
            if (done) begin
                ndone++;
                n_checks++;
                // done lands on the 23rd cycle counting the start cycle as the 1st
                if (cyc != 22) begin
                    n_fail++;
                    $display("FAIL done_latency: cycle %0d required 22", cyc);
                end
                start  = 1'b1;
                key_in = 128'h00112233445566778899aabbccddeeff;
            end
            if (cyc == 23 || cyc == 24) begin
                n_checks++;
                if (busy !== 1'b0 || rk_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_at_fin: cycle %0d busy=%b valid=%b required 0 0", cyc, busy, rk_valid);
                end
            end
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (idx != 11 || ndone != 1) begin
            n_fail++;
            $display("FAIL fips_count: keys=%0d dones=%0d required 11 1", idx, ndone);
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_zero_key;
        int got;
        got = 0;
        rk_ready = 1'b1;
        kick(128'd0);
        for (int c = 0; c < 10; c++) begin
            if (rk_valid && rk_index == 4'd1) begin
                got = 1;
                n_checks++;
                if (rk_out !== 128'h62636363626363636263636362636363) begin
                    n_fail++;
                    $display("FAIL zero_key_rk1: out=%h required 62636363626363636263636362636363", rk_out);
                end
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got == 0) begin
            n_fail++;
            $display("FAIL zero_key_timeout: rk1 seen=%0d required 1", got);
        end
        drain();
    endtask

    task automatic test_backpressure;
        int found;
        found = 0;
        rk_ready = 1'b1;
        kick(FIPS_KEY);
        for (int c = 0; c < 40; c++) begin
            if (rk_valid && rk_index == 4'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        rk_ready = 1'b0;
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL bp_reach_idx3: found=%0d required 1", found);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (rk_valid !== 1'b1 || rk_index !== 4'd3 || rk_out !== fips[3]) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b idx=%0d out=%h required 1 3 %h", rk_valid, rk_index, rk_out, fips[3]);
            end
        end
        rk_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_calc_gap: valid=%b required 0", rk_valid);
        end
        @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b1 || rk_index !== 4'd4 || rk_out !== fips[4]) begin
            n_fail++;
            $display("FAIL bp_next_key: valid=%b idx=%0d out=%h required 1 4 %h", rk_valid, rk_index, rk_out, fips[4]);
        end
        drain();
    endtask

    task automatic test_start_ignored;
        int idx, pulsed;
        idx = 0; pulsed = 0;
        rk_ready = 1'b1;
        kick(FIPS_KEY);
        for (int c = 0; c < 60 && !done; c++) begin
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (rk_index !== 4'(idx) || idx > 10 || rk_out !== fips[idx > 10 ? 10 : idx]) begin
                    n_fail++;
                    $display("FAIL start_busy_key: idx=%0d out=%h required idx=%0d", rk_index, rk_out, idx);
                end
                if (idx == 5 && pulsed == 0) begin
                    pulsed = 1;
                    start  = 1'b1;
                    key_in = 128'hffeeddccbbaa99887766554433221100;
                end
                idx++;
            end
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (idx != 11 || pulsed != 1) begin
            n_fail++;
            $display("FAIL start_busy_count: keys=%0d pulsed=%0d required 11 1", idx, pulsed);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        int found, ndone, idx;
        found = 0; ndone = 0; idx = 0;
        rk_ready = 1'b1;
        kick(FIPS_KEY);
        for (int c = 0; c < 40; c++) begin
            if (rk_valid && rk_index == 4'd6) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (found == 0 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_index !== 4'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: found=%0d valid=%b busy=%b idx=%0d done=%b required 1 0 0 0 0",
                     found, rk_valid, busy, rk_index, done);
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: active cycles=%0d required 0", ndone);
        end
        kick(FIPS_KEY);
        for (int c = 0; c < 40 && !done; c++) begin
            if (rk_valid && rk_ready) begin
                n_checks++;
                if (rk_index !== 4'(idx) || idx > 10 || rk_out !== fips[idx > 10 ? 10 : idx]) begin
                    n_fail++;
                    $display("FAIL restart_key: idx=%0d out=%h required idx=%0d", rk_index, rk_out, idx);
                end
                idx++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (idx != 11) begin
            n_fail++;
            $display("FAIL restart_count: keys=%0d required 11", idx);
        end
        drain();
    endtask

    task automatic test_random;
        logic [127:0] k;
        int idx;
        for (int n = 0; n < 20; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            idx = 0;
            rk_ready = 1'b0;
            kick(k);
            for (int c = 0; c < 400 && !done; c++) begin
                rk_ready = 1'($urandom_range(0, 1));
                if (rk_valid && rk_ready) begin
                    n_checks++;
                    if (rk_index !== 4'(idx) || idx > 10 || rk_out !== model_keys[idx > 10 ? 10 : idx]) begin
                        n_fail++;
                        $display("FAIL random_key: key %0d idx=%0d out=%h required idx=%0d", n, rk_index, rk_out, idx);
                    end
                    idx++;
                end
                @(negedge clk);
            end
            n_checks++;
            if (idx != 11) begin
                n_fail++;
                $display("FAIL random_count: key %0d transfers=%0d required 11", n, idx);
            end
            drain();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        init_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
